// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous RAM between the VGA scanout reader, the
// CPU fetch unit and the CPU load/store path.
//
// VGA wins by default. Once VGA has taken VGA_MAX_STREAK grants in a row while
// a CPU request was waiting, the CPU gets the next slot. Fetch and data
// alternate when both are waiting.
//
// Ports
//   clk, rst_sync                  clock, synchronous active-high reset
//   vga_req/addr   -> vga_gnt      VGA read request, grant
//   vga_rvalid                     mem_rdata carries VGA read data
//   fetch_req/addr -> fetch_gnt    fetch read request, grant
//   fetch_rvalid                   mem_rdata carries fetch read data
//   data_req/we/addr/wdata         load/store request
//   data_gnt, data_rvalid          load/store grant, load data valid
//   mem_en/we/addr/wdata           RAM command
//   mem_rdata                      RAM read data (1-cycle latency), shared
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int VGA_MAX_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst_sync,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int         N_REQ        = 3;   // index 0 = vga, 1 = fetch, 2 = data
    localparam logic [3:0] STREAK_LIMIT = 4'(VGA_MAX_STREAK);

    // Read-return owner. Requester index gi is encoded as gi + 1 so the
    // rvalid decode below can be generated.
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_VGA   = 2'd1;
    localparam logic [1:0] OWN_FETCH = 2'd2;
    localparam logic [1:0] OWN_DATA  = 2'd3;

    logic [3:0]       r_streak;
    logic [3:0]       w_streak_next;
    logic             r_last_cpu;       // 0 = fetch went last, 1 = data went last
    logic             w_last_cpu_next;
    logic [1:0]       r_owner;
    logic [1:0]       w_owner_next;

    logic             w_cpu_pend;
    logic             w_at_limit;
    logic             w_vga_win;
    logic             w_fetch_win;
    logic             w_data_win;
    logic [N_REQ-1:0] w_gnt;
    logic [N_REQ-1:0] w_rvalid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_streak   <= 4'd0;
            r_last_cpu <= 1'b1;
            r_owner    <= OWN_NONE;
        end else begin
            r_streak   <= w_streak_next;
            r_last_cpu <= w_last_cpu_next;
            r_owner    <= w_owner_next;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_cpu_pend  = fetch_req | data_req;
        // VGA loses its fixed priority only while a CPU request is actually
        // waiting; VGA running alone is never throttled.
        w_at_limit  = w_cpu_pend && (r_streak == STREAK_LIMIT);
        w_vga_win   = vga_req && !w_at_limit;
        // last_cpu = 1 means data went last, so fetch is next in turn.
        w_fetch_win = !w_vga_win && fetch_req && (!data_req || r_last_cpu);
        w_data_win  = !w_vga_win && data_req && (!fetch_req || !r_last_cpu);
        // Reset masks grants so a request in a reset cycle is simply retried.
        w_gnt       = rst_sync ? '0 : {w_data_win, w_fetch_win, w_vga_win};
    end

    always_comb begin
        w_streak_next   = 4'd0;
        w_last_cpu_next = r_last_cpu;
        w_owner_next    = OWN_NONE;
        if (w_gnt[0]) begin
            w_owner_next = OWN_VGA;
            // Count only grants that actually made a CPU request wait.
            if (w_cpu_pend && (r_streak != STREAK_LIMIT)) begin
                w_streak_next = r_streak + 4'd1;
            end else begin
                w_streak_next = r_streak;
            end
        end
        if (w_gnt[1]) begin
            w_last_cpu_next = 1'b0;
            w_owner_next    = OWN_FETCH;
        end
        if (w_gnt[2]) begin
            w_last_cpu_next = 1'b1;
            // Stores return nothing.
            w_owner_next    = data_we ? OWN_NONE : OWN_DATA;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = |w_gnt;
        mem_we    = w_gnt[2] & data_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt[0]) begin
            mem_addr = vga_addr;
        end else if (w_gnt[1]) begin
            mem_addr = fetch_addr;
        end else if (w_gnt[2]) begin
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    // A return in flight when reset arrives is dropped immediately rather
    // than one cycle later.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rvalid
            assign w_rvalid[gi] = !rst_sync && (r_owner == 2'(gi + 1));
        end
    endgenerate

    assign vga_gnt      = w_gnt[0];
    assign fetch_gnt    = w_gnt[1];
    assign data_gnt     = w_gnt[2];
    assign vga_rvalid   = w_rvalid[0];
    assign fetch_rvalid = w_rvalid[1];
    assign data_rvalid  = w_rvalid[2];

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port synchronous video/program RAM between three requesters: the VGA scanout reader, the CPU fetch unit and the CPU load/store path.
- Sits between those requesters and the RAM macro.
- VGA has fixed priority, bounded by a starvation limit so the CPU always makes progress.
- Fetch and data share the CPU slots round-robin.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 8, data width.
- VGA_MAX_STREAK, 3, maximum consecutive VGA grants while any CPU request is pending; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_sync  in  1  synchronous active-high reset.
- vga_req  in  1  VGA read request, held until granted.
- vga_addr  in  ADDR_W  VGA read address.
- vga_gnt  out  1  VGA granted this cycle.
- vga_rvalid  out  1  mem_rdata holds VGA read data.
- fetch_req  in  1  fetch read request, held until granted.
- fetch_addr  in  ADDR_W  fetch address.
- fetch_gnt  out  1  fetch granted this cycle.
- fetch_rvalid  out  1  mem_rdata holds fetch read data.
- data_req  in  1  load/store request, held until granted.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_gnt  out  1  load/store granted this cycle.
- data_rvalid  out  1  mem_rdata holds load data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read with mem_en=1; broadcast to all requesters.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst_sync): sampled only on posedge clk.
- Grants are combinational from the req inputs and registered state. At most one *_gnt is high per cycle.
- mem_en = OR of all grants.
- mem_addr and mem_we come from the granted requester; mem_we = data_gnt & data_we.
- When no grant: mem_we = 0; mem_addr and mem_wdata hold don't-care values, driven as 0.
- While rst_sync = 1: all *_gnt, mem_en and mem_we are forced to 0.
- Registered state:
  - streak counter (4 bits).
  - last_cpu flag, 0 = fetch, 1 = data.
  - read-return owner: none / vga / fetch / data.
- Reset values:
  - streak = 0, last_cpu = 1, owner = none.
  - All *_rvalid = 0.
- Priority, evaluated each cycle:
  - cpu_pend = fetch_req | data_req.
  - If vga_req and !(cpu_pend and streak == VGA_MAX_STREAK): grant VGA.
  - Otherwise, if both CPU requests are pending: grant fetch when last_cpu = 1, else grant data.
  - Otherwise, grant whichever single CPU request is pending.
- Streak update:
  - On a VGA grant with cpu_pend = 1: streak increments.
  - On a VGA grant with cpu_pend = 0: streak holds. It never exceeds VGA_MAX_STREAK.
  - On a CPU grant or an idle cycle: streak clears to 0.
- last_cpu updates only on a CPU grant: 0 after a fetch grant, 1 after a data grant.
- Read return:
  - A read grant (VGA, fetch, or data with we = 0) sets owner for the next cycle.
  - *_rvalid = (owner == that requester), registered: high exactly one cycle, 1 cycle after the grant.
  - Stores produce no rvalid.
  - Back-to-back reads pipeline: one return per cycle.
- Requesters must keep req and their address/data stable until gnt. They may deassert req in the cycle after gnt; if req is still high in that cycle, it is a new request.
- Reset mid-operation: an outstanding return is squashed (rvalid stays 0). A request granted in the same cycle as rst_sync is not granted and must be retried.

Test Plan:
- Reset:
  - Stimulus: rst_sync = 1 for 2 cycles with all reqs high.
  - Required: all gnt, mem_en and rvalid stay 0.
  - Stimulus: release reset with fetch_req and data_req high.
  - Required: first grant is fetch (last_cpu resets to 1).
- Single read:
  - Stimulus: fetch_req, addr 0x0123; RAM returns 0xA5.
  - Required: fetch_gnt and mem_en high in cycle N with mem_addr = 0x0123, mem_we = 0; fetch_rvalid high only in cycle N+1 with mem_rdata = 0xA5.
- Store:
  - Stimulus: data_req, we = 1, addr 0x0040, wdata 0x3C.
  - Required: data_gnt, mem_en and mem_we high for one cycle with matching addr and wdata; data_rvalid never asserted.
- Round-robin:
  - Stimulus: fetch_req and data_req held high for 4 cycles.
  - Required: grant sequence fetch, data, fetch, data; rvalids follow 1 cycle later in the same order.
- Starvation limit (VGA_MAX_STREAK = 3):
  - Stimulus: vga_req and fetch_req held high.
  - Required: grants VGA, VGA, VGA, fetch, VGA, VGA, VGA, fetch.
  - Stimulus: vga_req high alone for 10 cycles.
  - Required: VGA granted every cycle.
- Reset mid-read:
  - Stimulus: VGA read granted in cycle N, rst_sync = 1 in cycle N+1.
  - Required: vga_rvalid stays 0 in N+1 and afterwards, until a new grant.
